// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter: tag width, tag pipeline
// entry and round-robin pointer advance.
package mult_arb_pkg;

   localparam int N_REQ_MAX = 16;

   function automatic int tag_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Tags are sized for the largest supported requester count so one entry
   // type serves every instance; unused upper bits stay zero.
   localparam int TAG_W = tag_w(N_REQ_MAX);

   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] tag;
   } tag_entry_t;

   function automatic logic [TAG_W-1:0] rr_next(input logic [TAG_W-1:0] ptr,
                                                input logic [TAG_W-1:0] gidx,
                                                input logic             xfer,
                                                input int               n);
      if (!xfer) return ptr;
      if (int'(gidx) == n - 1) return '0;
      return gidx + TAG_W'(1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant starting at ptr, with the pointer moving
// one past the winner whenever a grant is issued.
module rr_arbiter
   import mult_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             en,
   output logic [N_REQ-1:0] grant,
   output logic [TAG_W-1:0] gnt_idx
);

   logic [TAG_W-1:0] ptr;
   logic             found;
   int               scan;

   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      scan    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         scan = int'(ptr) + k;
         if (scan >= N_REQ) scan = scan - N_REQ;
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && en && req[i] && i == scan) begin
               grant[i] = 1'b1;
               gnt_idx  = TAG_W'(i);
               found    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ptr <= '0;
      else        ptr <= rr_next(ptr, gnt_idx, |grant, N_REQ);
   end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one fixed-latency pipelined multiplier among N_REQ requesters; a tag
// pipeline matched to the multiplier latency routes each product back.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int WL      = 32,
   parameter int MUL_LAT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [N_REQ-1:0]    req_valid,
   output logic [N_REQ-1:0]    req_ready,
   input  logic [N_REQ*WL-1:0] req_a,
   input  logic [N_REQ*WL-1:0] req_b,
   output logic [N_REQ-1:0]    resp_valid,
   output logic [2*WL-1:0]     resp_product,
   output logic                mul_start,
   output logic [WL-1:0]       mul_multiplier,
   output logic [WL-1:0]       mul_multiplicand,
   input  logic                mul_done,
   input  logic [2*WL-1:0]     mul_product,
   output logic                busy,
   output logic                protocol_err
);

   logic [N_REQ-1:0] grant;
   logic [TAG_W-1:0] gnt_idx;
   logic [TAG_W-1:0] tag_p0;
   logic [WL-1:0]    sel_a;
   logic [WL-1:0]    sel_b;
   tag_entry_t       tag_pipe [MUL_LAT];
   tag_entry_t       tag_out;
   logic             any_vld;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .en      (enable),
      .grant   (grant),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = grant;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == TAG_W'(i)) begin
            sel_a = req_a[i*WL +: WL];
            sel_b = req_b[i*WL +: WL];
         end
      end
   end

   // Issue stage: operands hold their last value when nothing is granted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_start        <= 1'b0;
         mul_multiplier   <= '0;
         mul_multiplicand <= '0;
         tag_p0           <= '0;
      end else begin
         mul_start <= |grant;
         if (|grant) begin
            mul_multiplier   <= sel_a;
            mul_multiplicand <= sel_b;
            tag_p0           <= gnt_idx;
         end
      end
   end

   // Tag pipeline: last entry lines up with mul_done of the same operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < MUL_LAT; k++) tag_pipe[k] <= '0;
      end else begin
         tag_pipe[0] <= {mul_start, tag_p0};
         for (int k = 1; k < MUL_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
      end
   end

   assign tag_out = tag_pipe[MUL_LAT-1];

   always_comb begin
      any_vld = 1'b0;
      for (int k = 0; k < MUL_LAT; k++) any_vld = any_vld | tag_pipe[k].vld;
   end

   assign busy = mul_start | any_vld;

   always_comb begin
      resp_valid = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (mul_done && tag_out.vld && tag_out.tag == TAG_W'(i)) resp_valid[i] = 1'b1;
      end
   end

   assign resp_product = mul_product;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                       protocol_err <= 1'b0;
      else if (mul_done != tag_out.vld) protocol_err <= 1'b1;
   end

endmodule
